// File: rtl/exp_pkg.sv
// Shared widths, FSM state encoding and result record for the exponential job driver.
package exp_pkg;

  localparam int X_W    = 16;
  localparam int INT_W  = 2;
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESULT
  } exp_drv_state_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac;
    logic              err;
  } exp_result_t;

endpackage

// File: rtl/exp_job_driver_if.sv
// Operand stream, accelerator handshake and result stream of the job driver.
interface exp_job_driver_if;
  import exp_pkg::*;

  logic              op_valid;
  logic              op_ready;
  logic [X_W-1:0]    op_x;

  logic              acc_start;
  logic [X_W-1:0]    acc_x;
  logic              acc_done;
  logic [INT_W-1:0]  acc_intpart;
  logic [FRAC_W-1:0] acc_fracpart;

  logic              res_valid;
  logic              res_ready;
  logic [X_W-1:0]    res_x;
  logic [INT_W-1:0]  res_int;
  logic [FRAC_W-1:0] res_frac;
  logic              res_err;

  logic              busy;

  // The job driver itself.
  modport master (
    input  op_valid, op_x, acc_done, acc_intpart, acc_fracpart, res_ready,
    output op_ready, acc_start, acc_x, res_valid, res_x, res_int, res_frac, res_err, busy
  );

  // The surroundings: upstream producer, accelerator and downstream consumer.
  modport slave (
    output op_valid, op_x, acc_done, acc_intpart, acc_fracpart, res_ready,
    input  op_ready, acc_start, acc_x, res_valid, res_x, res_int, res_frac, res_err, busy
  );

endinterface

// File: rtl/exp_op_fifo.sv
// Operand FIFO: power-of-two depth, head visible from storage, push blocked when full.
module exp_op_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array is not reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exp_job_driver.sv
// Issues buffered operands one at a time to the exponential accelerator, bounds each
// job with a timeout and returns operand plus result on a valid/ready stream.
module exp_job_driver
  import exp_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst_n,
  exp_job_driver_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  exp_drv_state_t    state;
  exp_drv_state_t    state_n;
  logic [X_W-1:0]    fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              done_hit;
  logic              timeout_hit;
  logic [CNT_W-1:0]  cnt;
  logic [X_W-1:0]    acc_x_q;
  exp_result_t       res_q;

  exp_op_fifo #(
    .DEPTH (DEPTH),
    .W     (X_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.op_valid),
    .wdata (bus.op_x),
    .pop   (pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and per-cycle job events; done outranks timeout, and done outside WAIT is ignored.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = START;
        end
      end
      START: state_n = WAIT;
      WAIT: begin
        if (bus.acc_done) begin
          done_hit = 1'b1;
          state_n  = RESULT;
        end else if (cnt == TO_CNT) begin
          timeout_hit = 1'b1;
          state_n     = RESULT;
        end
      end
      RESULT: begin
        if (bus.res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand register, timeout counter and captured result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x_q <= '0;
      cnt     <= '0;
      res_q   <= '0;
    end else begin
      if (pop) acc_x_q <= fifo_head;

      if (state == START) cnt <= '0;
      else if (state == WAIT && !done_hit && !timeout_hit) cnt <= cnt + 1'b1;

      if (done_hit) begin
        res_q <= '{x: acc_x_q, int_part: bus.acc_intpart, frac: bus.acc_fracpart, err: 1'b0};
      end else if (timeout_hit) begin
        res_q <= '{x: acc_x_q, int_part: '0, frac: '0, err: 1'b1};
      end
    end
  end

  // Outputs decode flops only; op_ready depends on the FIFO count alone.
  assign bus.op_ready  = !fifo_full;
  assign bus.acc_start = (state == START);
  assign bus.acc_x     = acc_x_q;
  assign bus.res_valid = (state == RESULT);
  assign bus.res_x     = res_q.x;
  assign bus.res_int   = res_q.int_part;
  assign bus.res_frac  = res_q.frac;
  assign bus.res_err   = res_q.err;
  assign bus.busy      = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_exp_job_driver.sv
// Directed bench for exp_job_driver with a stub accelerator and an in-order result scoreboard.
module tb_exp_job_driver;
  import exp_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int LAT     = 5;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic              stub_done = 1'b0;
  logic              inj_done  = 1'b0;
  logic              hang      = 1'b0;
  logic [INT_W-1:0]  stub_int  = '0;
  logic [FRAC_W-1:0] stub_frac = '0;

  exp_result_t sb[$];

  always #5 clk = ~clk;

  exp_job_driver_if bus ();

  assign bus.acc_done     = stub_done | inj_done;
  assign bus.acc_intpart  = stub_int;
  assign bus.acc_fracpart = stub_frac;

  exp_job_driver #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of the stub accelerator, plus the timeout outcome.
  function automatic exp_result_t model(input logic [15:0] x, input logic err);
    exp_result_t r;
    r.x = x;
    if (err) begin
      r.int_part = '0;
      r.frac     = '0;
      r.err      = 1'b1;
    end else begin
      r.int_part = 2'd1 + {1'b0, x[15]};
      r.frac     = {x[7:0], x[15:8]};
      r.err      = 1'b0;
    end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_op_ready"},  bus.op_ready,  1);
    check({tag, "_acc_start"}, bus.acc_start, 0);
    check({tag, "_acc_x"},     bus.acc_x,     0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_res_x"},     bus.res_x,     0);
    check({tag, "_res_int"},   bus.res_int,   0);
    check({tag, "_res_frac"},  bus.res_frac,  0);
    check({tag, "_res_err"},   bus.res_err,   0);
    check({tag, "_busy"},      bus.busy,      0);
  endtask

  task automatic push_op(input logic [15:0] x, input logic err);
    int n = 0;
    bus.op_valid = 1'b1;
    bus.op_x     = x;
    while (!bus.op_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bus.op_ready, 1);
    sb.push_back(model(x, err));
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stub accelerator: done pulse LAT cycles after the start cycle unless hung.
  initial begin
    logic [15:0] sx;
    int k;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.acc_start && !hang) begin
        sx = bus.acc_x;
        k  = 0;
        while (k < LAT && rst_n) begin
          @(negedge clk);
          k++;
        end
        if (rst_n) begin
          stub_done = 1'b1;
          stub_int  = 2'd1 + {1'b0, sx[15]};
          stub_frac = {sx[7:0], sx[15:8]};
          @(negedge clk);
          stub_done = 1'b0;
        end
      end
    end
  end

  // Monitor: issue order, start pulse shape, operand stability and result scoreboard.
  initial begin
    int          last_start;
    bit          in_job;
    bit          prev_start;
    exp_result_t e;
    last_start = -100;
    in_job     = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        in_job     = 1'b0;
        prev_start = 1'b0;
        continue;
      end
      if (bus.acc_start) begin
        check("start_single", prev_start, 0);
        check("start_gap", (cyc - last_start) >= (LAT + 3), 1);
        last_start = cyc;
        in_job     = 1'b1;
        if (sb.size() == 0) check("unexpected_start", bus.acc_start, 0);
        else                check("acc_x_issue", bus.acc_x, sb[0].x);
      end else if (in_job && !bus.res_valid && sb.size() != 0) begin
        check("acc_x_stable", bus.acc_x, sb[0].x);
      end
      if (bus.res_valid) in_job = 1'b0;
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", bus.res_valid, 0);
        end else begin
          e = sb.pop_front();
          check("res_x",    bus.res_x,    e.x);
          check("res_int",  bus.res_int,  e.int_part);
          check("res_frac", bus.res_frac, e.frac);
          check("res_err",  bus.res_err,  e.err);
        end
      end
      prev_start = bus.acc_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n         = 1'b0;
    bus.op_valid  = 1'b0;
    bus.op_x      = '0;
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Single job, latency 5: start at c+2, result at c+8.
    bus.op_valid = 1'b1;
    bus.op_x     = 16'h0000;
    sb.push_back(model(16'h0000, 1'b0));
    @(negedge clk);
    bus.op_valid = 1'b0;
    check("t1_start_c1", bus.acc_start, 0);
    @(negedge clk);
    check("t1_start_c2", bus.acc_start, 1);
    repeat (5) @(negedge clk);
    check("t1_valid_c7", bus.res_valid, 0);
    @(negedge clk);
    check("t1_valid_c8", bus.res_valid, 1);
    check("t1_int", bus.res_int, 1);
    drain(20);

    // Back-to-back operands with the consumer always ready.
    push_op(16'hFFFF, 1'b0);
    push_op(16'h8000, 1'b0);
    push_op(16'h4000, 1'b0);
    drain(100);

    // Fill the FIFO behind a job stalled in RESULT.
    bus.res_ready = 1'b0;
    push_op(16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    push_op(16'h2222, 1'b0);
    push_op(16'h3333, 1'b0);
    push_op(16'h4444, 1'b0);
    push_op(16'h5555, 1'b0);
    check("full_op_ready", bus.op_ready, 0);
    check("full_busy", bus.busy, 1);
    bus.op_valid = 1'b1;
    bus.op_x     = 16'h6666;
    repeat (3) begin
      @(negedge clk);
      check("full_blocked", bus.op_ready, 0);
    end
    bus.op_valid = 1'b0;

    // Result held for 20 cycles: stable data, no new issue.
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", bus.res_valid, 1);
    repeat (20) begin
      @(negedge clk);
      check("hold_data", {bus.res_valid, bus.acc_start, bus.res_x, bus.res_int, bus.res_frac},
            {1'b1, 1'b0, sb[0].x, sb[0].int_part, sb[0].frac});
    end
    bus.res_ready = 1'b1;
    drain(200);

    // Hung accelerator: timeout result 10 cycles after start, late done dropped.
    hang = 1'b1;
    push_op(16'h1234, 1'b1);
    n = 0;
    while (!bus.acc_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("to_start_seen", bus.acc_start, 1);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("to_latency", n, TIMEOUT + 2);
    @(negedge clk);
    inj_done = 1'b1;
    repeat (2) @(negedge clk);
    inj_done = 1'b0;
    check("late_done_valid", bus.res_valid, 0);
    check("late_done_busy", bus.busy, 0);
    hang = 1'b0;
    push_op(16'h0ABC, 1'b0);
    drain(100);

    // Reset in WAIT with two operands queued.
    hang = 1'b1;
    push_op(16'h7777, 1'b1);
    push_op(16'h8888, 1'b1);
    push_op(16'h9999, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    check("pre_rst_acc_x", bus.acc_x, 16'h7777);
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hang  = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("post_rst_quiet", {bus.res_valid, bus.acc_start, bus.busy}, 3'b000);
    end
    push_op(16'h0F0F, 1'b0);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
